// File: rtl/countdown16_if.sv
// Control/data bundle for countdown16: commands in, count and status out.
interface countdown16_if;
    logic        load;
    logic [15:0] in;
    logic        start;
    logic        pause;
    logic        abort;
    logic        dec;
    logic        auto_reload;
    logic [15:0] out;
    logic        zero;
    logic        busy;
    logic        done;

    // Driver side (testbench / controlling logic).
    modport master (
        output load, in, start, pause, abort, dec, auto_reload,
        input  out, zero, busy, done
    );

    // Counter side.
    modport slave (
        input  load, in, start, pause, abort, dec, auto_reload,
        output out, zero, busy, done
    );
endinterface

// File: rtl/countdown16.sv
// 16-bit countdown timer with pause, abort, single-step decrement and
// optional auto-reload on terminal count.
module countdown16 (
    input  logic          clk,
    input  logic          rst_n,
    countdown16_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] reload_reg;
    logic        done_q;

    assign bus.out  = cnt;
    assign bus.zero = (cnt == 16'h0000);
    assign bus.busy = (state == RUN);
    assign bus.done = done_q;

    // Command priority: abort, then load, then per-state start/dec/decrement.
    // done_q is raised only on entry to DONE, so it is a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 16'h0000;
            reload_reg <= 16'h0000;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort) begin
                state <= IDLE;
            end else if (bus.load) begin
                cnt        <= bus.in;
                reload_reg <= bus.in;
                case (state)
                    RUN: begin
                        if (bus.in == 16'h0000) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                    // Leaving DONE uses the freshly loaded value as reload.
                    DONE: begin
                        if (bus.auto_reload && bus.in != 16'h0000)
                            state <= RUN;
                        else
                            state <= IDLE;
                    end
                    default: ;
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            if (cnt != 16'h0000) begin
                                state <= RUN;
                            end else begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end
                        end else if (bus.dec) begin
                            cnt <= cnt - 16'h0001;
                        end
                    end
                    RUN: begin
                        if (!bus.pause) begin
                            // Never wrap while running; 0 in RUN just terminates.
                            if (cnt <= 16'h0001) begin
                                cnt    <= 16'h0000;
                                state  <= DONE;
                                done_q <= 1'b1;
                            end else begin
                                cnt <= cnt - 16'h0001;
                            end
                        end
                    end
                    DONE: begin
                        if (bus.auto_reload && reload_reg != 16'h0000) begin
                            cnt   <= reload_reg;
                            state <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown16.sv
// Directed bench for countdown16: hand-computed vectors, sampled 1ns after
// each rising edge.
module tb_countdown16;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    countdown16_if bus ();

    countdown16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input string tag, input logic [15:0] o, input logic b, input logic d);
        chk({tag, ".out"},  {16'h0, bus.out}, {16'h0, o});
        chk({tag, ".busy"}, {31'h0, bus.busy}, {31'h0, b});
        chk({tag, ".done"}, {31'h0, bus.done}, {31'h0, d});
        chk({tag, ".zero"}, {31'h0, bus.zero}, {31'h0, (o == 16'h0)});
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        bus.load = 0; bus.in = 0; bus.start = 0; bus.pause = 0;
        bus.abort = 0; bus.dec = 0; bus.auto_reload = 0;
        #12;
        st("reset", 16'h0, 0, 0);
        rst_n = 1'b1;
        step();

        // Basic countdown from 3
        bus.load = 1; bus.in = 16'h0003; step(); bus.load = 0;
        st("basic.load", 16'h3, 0, 0);
        bus.start = 1; step(); bus.start = 0;
        st("basic.c1", 16'h3, 1, 0);
        step(); st("basic.c2", 16'h2, 1, 0);
        step(); st("basic.c3", 16'h1, 1, 0);
        step(); st("basic.term", 16'h0, 0, 1);
        step(); st("basic.idle", 16'h0, 0, 0);

        // Wrap-around via dec in IDLE
        bus.dec = 1; step(); st("wrap.1", 16'hFFFF, 0, 0);
        step(); st("wrap.2", 16'hFFFE, 0, 0);
        // start+dec together obeys start
        bus.start = 1; step(); bus.start = 0; bus.dec = 0;
        st("startdec", 16'hFFFE, 1, 0);
        bus.abort = 1; step(); bus.abort = 0;
        st("startdec.abort", 16'hFFFE, 0, 0);

        // Pause and abort
        bus.load = 1; bus.in = 16'h0010; step(); bus.load = 0;
        bus.start = 1; step(); bus.start = 0;
        st("pause.run", 16'h10, 1, 0);
        step(); step(); st("pause.pre", 16'h0E, 1, 0);
        bus.pause = 1;
        for (int i = 0; i < 4; i++) begin
            step(); st("pause.hold", 16'h0E, 1, 0);
        end
        bus.pause = 0; step(); st("pause.resume", 16'h0D, 1, 0);
        bus.abort = 1; step(); bus.abort = 0;
        st("abort", 16'h0D, 0, 0);
        step(); st("abort.idle", 16'h0D, 0, 0);

        // Zero start
        bus.load = 1; bus.in = 16'h0; step(); bus.load = 0;
        st("zstart.load", 16'h0, 0, 0);
        bus.start = 1; step(); bus.start = 0;
        st("zstart.done", 16'h0, 0, 1);
        step(); st("zstart.idle", 16'h0, 0, 0);

        // Auto-reload with value 2
        bus.auto_reload = 1;
        bus.load = 1; bus.in = 16'h0002; step(); bus.load = 0;
        bus.start = 1; step(); bus.start = 0;
        st("ar.a2", 16'h2, 1, 0);
        step(); st("ar.a1", 16'h1, 1, 0);
        step(); st("ar.a0", 16'h0, 0, 1);
        step(); st("ar.b2", 16'h2, 1, 0);
        step(); st("ar.b1", 16'h1, 1, 0);
        step(); st("ar.b0", 16'h0, 0, 1);
        // load while in DONE overrides the reload value
        bus.load = 1; bus.in = 16'h0005; step(); bus.load = 0;
        st("ar.override", 16'h5, 1, 0);
        step(); st("ar.ov4", 16'h4, 1, 0);
        bus.auto_reload = 0;
        // load 0 while RUN terminates immediately
        bus.load = 1; bus.in = 16'h0; step(); bus.load = 0;
        st("runload0", 16'h0, 0, 1);
        step(); st("runload0.idle", 16'h0, 0, 0);

        // Async reset mid-RUN
        bus.load = 1; bus.in = 16'h1234; step(); bus.load = 0;
        bus.start = 1; step(); bus.start = 0;
        st("areset.run", 16'h1234, 1, 0);
        #2 rst_n = 1'b0;
        #1 st("areset.now", 16'h0, 0, 0);
        step();
        #2 rst_n = 1'b1;
        step(); st("areset.after", 16'h0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
